// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin arbiter owning one shared W-bit register
// A granted requester writes once per cycle while it holds req and lock, up to MAX_HOLD writes.
module shared_reg_arbiter #(
  parameter int W        = 8,
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ*W-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [W-1:0]      q,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   ptr, ptr_next;
  logic [PW-1:0]   owner, owner_next;
  logic [3:0]      hold, hold_next;
  logic [3:0]      hold_inc;
  logic [W-1:0]    q_r, q_next;
  logic [NREQ-1:0] gnt_r, gnt_next;
  logic [NREQ-1:0] ack_r, ack_next;
  logic            busy_r, busy_next;
  logic            found;
  logic [PW-1:0]   winner;
  logic            commit;
  logic [W-1:0]    wd [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign wd[i] = wdata[i*W +: W];
  end

  // Search upward from the slot after the last winner, wrapping once.
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_v;
    found  = 1'b0;
    winner = ptr;
    idx    = 0;
    idx_v  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_v = PW'(idx);
      if (!found && req[idx_v]) begin
        found  = 1'b1;
        winner = idx_v;
      end
    end
  end

  assign hold_inc = hold + 4'd1;
  assign commit   = (state == OWNED) && req[owner];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= PW'(NREQ - 1);
      owner  <= '0;
      hold   <= '0;
      q_r    <= '0;
      gnt_r  <= '0;
      ack_r  <= '0;
      busy_r <= 1'b0;
    end else begin
      state  <= state_next;
      ptr    <= ptr_next;
      owner  <= owner_next;
      hold   <= hold_next;
      q_r    <= q_next;
      gnt_r  <= gnt_next;
      ack_r  <= ack_next;
      busy_r <= busy_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    owner_next = owner;
    hold_next  = hold;
    case (state)
      IDLE: begin
        if (found) begin
          state_next = OWNED;
          ptr_next   = winner;
          owner_next = winner;
          hold_next  = '0;
        end
      end
      OWNED: begin
        if (req[owner]) begin
          hold_next = hold_inc;
          if (!(lock[owner] && (hold_inc < 4'(MAX_HOLD)))) state_next = IDLE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs are derived from the state being entered so they line up with it.
  always_comb begin
    gnt_next  = '0;
    ack_next  = '0;
    q_next    = q_r;
    busy_next = (state_next == OWNED);
    if (state_next == OWNED) gnt_next = NREQ'(1) << owner_next;
    if (commit) begin
      ack_next = NREQ'(1) << owner;
      q_next   = wd[owner];
    end
  end

  assign gnt  = gnt_r;
  assign ack  = ack_r;
  assign q    = q_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - directed and randomized bench for shared_reg_arbiter
module tb_shared_reg_arbiter;
  localparam int W        = 8;
  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   lock = '0;
  logic [NREQ*W-1:0] wdata = '0;
  logic [NREQ-1:0]   gnt, ack;
  logic [W-1:0]      q;
  logic              busy;

  int errors = 0;
  int checks = 0;

  bit           m_owned;
  int           m_owner, m_ptr, m_hold;
  logic [W-1:0] m_q;
  logic [3:0]   m_gnt, m_ack;

  logic [31:0]  rr_data;

  shared_reg_arbiter #(.W(W), .NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .wdata(wdata),
    .gnt(gnt), .ack(ack), .q(q), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_owned = 1'b0;
    m_owner = 0;
    m_ptr   = NREQ - 1;
    m_hold  = 0;
    m_q     = '0;
    m_gnt   = '0;
    m_ack   = '0;
  endtask

  // Transaction-level reference: who owns the register, how many writes it has made.
  task automatic m_step();
    m_ack = '0;
    if (!m_owned) begin
      if (req != '0) begin
        for (int k = 1; k <= NREQ; k++) begin
          int c;
          c = (m_ptr + k) % NREQ;
          if (req[c]) begin
            m_owner = c;
            break;
          end
        end
        m_ptr   = m_owner;
        m_owned = 1'b1;
        m_hold  = 0;
        m_gnt   = 4'(1 << m_owner);
      end
    end else if (req[m_owner]) begin
      m_q    = wdata[m_owner*W +: W];
      m_ack  = 4'(1 << m_owner);
      m_hold = m_hold + 1;
      if (!(lock[m_owner] && m_hold < MAX_HOLD)) begin
        m_owned = 1'b0;
        m_gnt   = '0;
      end
    end else begin
      m_owned = 1'b0;
      m_gnt   = '0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".gnt"},  32'(gnt),  32'(m_gnt));
    check({tag, ".ack"},  32'(ack),  32'(m_ack));
    check({tag, ".q"},    32'(q),    32'(m_q));
    check({tag, ".busy"}, 32'(busy), 32'(m_owned));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    m_step();
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    m_reset();
    compare_all("reset");
    rst = 1'b1;
  endtask

  initial begin
    #3;
    m_reset();
    compare_all("por");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single request
    do_reset();
    req = 4'b0001; wdata = 32'h0000_00A5;
    cycle("single1");
    check("single_gnt", 32'(gnt), 32'h1);
    cycle("single2");
    check("single_q", 32'(q), 32'hA5);
    check("single_ack", 32'(ack), 32'h1);
    check("single_gnt_clr", 32'(gnt), 32'h0);
    check("single_busy", 32'(busy), 32'h0);
    req = '0;
    cycle("single3");

    // Round-robin with all requesting
    do_reset();
    rr_data = 32'h4433_2211;
    req = 4'b1111; lock = '0; wdata = rr_data;
    for (int g = 0; g < 5; g++) begin
      cycle("rr_grant");
      check("rr_order", 32'(gnt), 32'(1 << (g % NREQ)));
      cycle("rr_write");
      check("rr_q", 32'(q), 32'(rr_data[8*(g % NREQ) +: 8]));
      check("rr_ack", 32'(ack), 32'(1 << (g % NREQ)));
    end
    req = '0;
    cycle("rr_end");

    // Lock up to the hold limit, then hand over to a waiting requester
    do_reset();
    req = 4'b0100; lock = 4'b0100; wdata = 32'h0001_0000;
    cycle("lock_grant");
    check("lock_gnt", 32'(gnt), 32'h4);
    req = 4'b0101;
    for (int k = 1; k <= MAX_HOLD; k++) begin
      cycle("lock_write");
      check("lock_q", 32'(q), 32'(k));
      check("lock_ack", 32'(ack), 32'h4);
      wdata[23:16] = 8'(k + 1);
    end
    check("lock_release", 32'(gnt), 32'h0);
    cycle("lock_next");
    check("lock_next_gnt", 32'(gnt), 32'h1);
    req = '0; lock = '0;
    cycle("lock_drop");
    check("lock_drop_ack", 32'(ack), 32'h0);

    // Owner drops its request while owned
    do_reset();
    req = 4'b0010; wdata = 32'h0000_7700;
    cycle("drop_grant");
    check("drop_gnt", 32'(gnt), 32'h2);
    req = '0;
    cycle("drop_rel");
    check("drop_ack", 32'(ack), 32'h0);
    check("drop_q", 32'(q), 32'h0);
    check("drop_gnt_clr", 32'(gnt), 32'h0);

    // Others arrive while requester 3 holds a lock
    do_reset();
    req = 4'b1000; lock = 4'b1000; wdata = 32'hD0C0_B0A0;
    cycle("sim_grant");
    check("sim_gnt3", 32'(gnt), 32'h8);
    req = 4'b1011;
    for (int k = 0; k < MAX_HOLD; k++) cycle("sim_hold");
    check("sim_release", 32'(gnt), 32'h0);
    lock = '0;
    cycle("sim_g0");
    check("sim_gnt0", 32'(gnt), 32'h1);
    cycle("sim_w0");
    cycle("sim_g1");
    check("sim_gnt1", 32'(gnt), 32'h2);
    req = '0;
    cycle("sim_w1");
    cycle("sim_end");

    // Asynchronous reset while owned
    do_reset();
    req = 4'b0001; lock = 4'b0001; wdata = 32'h0000_003C;
    cycle("ar_grant");
    cycle("ar_write");
    check("ar_q", 32'(q), 32'h3C);
    check("ar_busy", 32'(busy), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    m_reset();
    check("ar_q0", 32'(q), 32'h0);
    check("ar_gnt0", 32'(gnt), 32'h0);
    check("ar_ack0", 32'(ack), 32'h0);
    check("ar_busy0", 32'(busy), 32'h0);
    rst = 1'b1;
    req = 4'b1000; lock = '0;
    cycle("ar_regrant");
    check("ar_gnt3", 32'(gnt), 32'h8);
    req = '0;
    cycle("ar_w");
    cycle("ar_end");

    // Randomized traffic against the reference
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end
      req   = 4'($urandom);
      lock  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
      wdata = $urandom;
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin arbiter that shares one W-bit register, a bank of D flip-flops, among NREQ requesters. It grants one requester at a time and writes that requester's data into the shared register. A requester may lock the register for several consecutive writes, up to a bounded hold limit. The block sits between the requesting agents and the register, and it is the only writer of the register.

## Interface
- W, default 8: width of the shared register and of each requester's data.
- NREQ, default 4: number of requesters. Legal range is 2..8.
- MAX_HOLD, default 4: maximum consecutive writes per grant. Legal range is 1..15.

Ports:
- clk, input, 1: clock. All state changes on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- req, input, NREQ: request, one bit per requester. Level-sensitive.
- lock, input, NREQ: ask to keep the grant after the current write.
- wdata, input, NREQ*W: requester i's data occupies bits [i*W +: W].
- gnt, output, NREQ: registered, one-hot or zero. Grant to the current owner.
- ack, output, NREQ: registered one-cycle pulse. Marks that requester's write was committed to q.
- q, output, W: the shared register contents.
- busy, output, 1: registered. High while the state is OWNED.

## Operation
State machine with two states, IDLE and OWNED.

Reset (asynchronous, takes effect immediately mid-operation):
- State goes to IDLE.
- q, gnt, ack and busy go to 0.
- Hold counter goes to 0.
- Last-winner pointer goes to NREQ-1, so requester 0 has top priority after reset.

IDLE:
- If req is nonzero, pick the winner by round-robin: the first set req bit searching upward from pointer+1, wrapping modulo NREQ.
- On the clock edge: gnt becomes onehot(winner), pointer becomes winner, state becomes OWNED, hold counter becomes 0.
- If req is zero, stay in IDLE.

OWNED, with owner o:
- If req[o] is high:
  - q takes wdata[o].
  - ack[o] pulses on the next cycle.
  - Hold counter increments.
  - Stay in OWNED only if lock[o] is high and the incremented count is below MAX_HOLD. Otherwise go to IDLE and clear gnt.
- If req[o] is low: no write, no ack, go to IDLE and clear gnt.
- Requests from other requesters are ignored while OWNED. They are arbitrated in the next IDLE cycle.

Pointer and fairness:
- The pointer advances only when a grant is issued.
- After a forced release, the former owner has the lowest priority in the next arbitration.

Other rules:
- ack is never asserted for more than one bit, and never for a requester that did not have gnt in the previous cycle.
- q changes only on a committed write or on reset.

## Timing
- Request to grant: req sampled high in IDLE cycle N gives gnt high in cycle N+1.
- Grant to write: in cycle N+1, wdata[o] is sampled. q holds the new value and ack[o] is high in cycle N+2.
- Minimum request-to-q latency is 2 cycles.
- A locked owner writes every cycle. Up to MAX_HOLD consecutive writes, with q updating each cycle.
- Every grant ends with at least one IDLE cycle, so grant to the next grant takes at least 2 cycles.
- busy equals (gnt != 0) on every cycle.
- Deasserting rst mid-operation has no partial effect. The first edge after release behaves as IDLE with the pointer at NREQ-1.

## Test plan
- Single request: after reset, req=0001 and wdata0=8'hA5 with no lock. gnt=0001 on cycle 1; q=8'hA5 and ack=0001 on cycle 2; gnt=0 and busy=0 on cycle 2; state returns to IDLE.
- Round-robin: req=1111 held with lock=0. Grant order is 0,1,2,3,0, with one grant every 2 cycles. ack follows the same order, and q tracks each winner's wdata.
- Lock and hold limit: req=0100 with lock=0100 held and wdata2 incrementing 1,2,3,…, MAX_HOLD=4. Exactly 4 consecutive writes (q = 1,2,3,4) with ack=0100 for 4 cycles, then gnt drops. The next grant goes to another waiting requester if one exists.
- Owner drops request: grant requester 1, then drop req[1] in the OWNED cycle. No ack, q unchanged, gnt clears on the next edge.
- Simultaneous arrival while owned: requester 3 owns with lock; req0 and req1 rise mid-hold. Both wait. After release, requester 0 wins (the first bit above pointer 3), then requester 1.
- Reset mid-operation: assert rst low between edges while OWNED with q=8'h3C. q, gnt, ack and busy go to 0 immediately, without waiting for a clock edge. After release, req=1000 is granted requester 3 normally.
